// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider with its control FSM for UDIV/SDIV in Execute.
// Stalls the front of the pipeline while iterating; a flush aborts without disturbing held results.
module div_sequencer #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             SignedE,
  input  logic [WIDTH-1:0] DividendE,
  input  logic [WIDTH-1:0] DivisorE,
  input  logic             FlushE,
  output logic             StallDivE,
  output logic             DoneE,
  output logic [WIDTH-1:0] QuotientE,
  output logic [WIDTH-1:0] RemainderE,
  output logic             DivZeroE
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t               state, stateNext;
  logic [CNT_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     remReg, quoReg, divisorMag;
  logic                 negQuo, negRem;
  logic [WIDTH-1:0]     quoOut, remOut;
  logic                 divZeroOut;

  logic                 accept, divZeroIn, keep;
  logic [WIDTH:0]       shifted, trial;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? (-v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (-v) : v;
  endfunction

  assign accept    = StartE && !FlushE && ((state == IDLE) || (state == DONE));
  assign divZeroIn = (DivisorE == '0);

  // One restoring step: shift next dividend bit into the partial remainder, trial-subtract.
  assign shifted = {remReg, quoReg[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisorMag};
  assign keep    = !trial[WIDTH];

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (accept) stateNext = divZeroIn ? DONE : DIV;
        else        stateNext = IDLE;
      end
      DIV: begin
        if (FlushE)           stateNext = IDLE;
        else if (cnt == '0)   stateNext = FIX;
      end
      FIX: stateNext = FlushE ? IDLE : DONE;
      default: stateNext = IDLE;
    endcase
  end

  // The accepting cycle stalls even for a zero divisor so Execute waits for the DONE result.
  assign StallDivE  = accept || (state == DIV) || (state == FIX);
  assign DoneE      = (state == DONE);
  assign QuotientE  = quoOut;
  assign RemainderE = remOut;
  assign DivZeroE   = divZeroOut;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorMag <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      quoOut     <= '0;
      remOut     <= '0;
      divZeroOut <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        negQuo     <= SignedE && (DividendE[WIDTH-1] ^ DivisorE[WIDTH-1]);
        negRem     <= SignedE && DividendE[WIDTH-1];
        divisorMag <= magnitude(DivisorE, SignedE);
        quoReg     <= magnitude(DividendE, SignedE);
        remReg     <= '0;
        cnt        <= CNT_WIDTH'(WIDTH - 1);
        if (divZeroIn) begin
          quoOut     <= '0;
          remOut     <= DividendE;
          divZeroOut <= 1'b1;
        end
      end else if ((state == DIV) && !FlushE) begin
        remReg <= keep ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quoReg <= {quoReg[WIDTH-2:0], keep};
        if (cnt != '0) cnt <= cnt - CNT_WIDTH'(1);
      end else if ((state == FIX) && !FlushE) begin
        quoOut     <= applySign(quoReg, negQuo);
        remOut     <= applySign(remReg, negRem);
        divZeroOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed boundary cases plus randomized divides
// compared against an arithmetic reference model.
module tb_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         StartE, SignedE, FlushE;
  logic [W-1:0] DividendE, DivisorE;
  logic         StallDivE, DoneE, DivZeroE;
  logic [W-1:0] QuotientE, RemainderE;

  int checks = 0;
  int errors = 0;

  div_sequencer #(.WIDTH(W), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .SignedE(SignedE),
    .DividendE(DividendE), .DivisorE(DivisorE), .FlushE(FlushE),
    .StallDivE(StallDivE), .DoneE(DoneE), .QuotientE(QuotientE),
    .RemainderE(RemainderE), .DivZeroE(DivZeroE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
    longint sa, sb;
    if (b == 0) begin
      q = 0; r = a; dz = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; dz = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0;
    end
  endtask

  // Called just after a falling edge: presents the request for the coming rising edge.
  task automatic startOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit s);
    StartE = 1'b1; SignedE = s; DividendE = a; DivisorE = b;
    #1;
    chk({tag, "_stall_acc"}, StallDivE, 1'b1);
  endtask

  // Counts falling edges since acceptance until DoneE, checking stall and results.
  task automatic waitDone(input string tag, input int startN, input int expLat,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz);
    int n;
    bit stallOk;
    n = startN;
    stallOk = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      StartE = 1'b0;
      n++;
      #1;
      if (DoneE) break;
      if (!StallDivE) stallOk = 1'b0;
    end
    chk({tag, "_lat"}, n, expLat);
    chk({tag, "_q"}, QuotientE, eq);
    chk({tag, "_r"}, RemainderE, er);
    chk({tag, "_dz"}, DivZeroE, edz);
    chk({tag, "_stall_done"}, StallDivE, 1'b0);
    chk({tag, "_stall_busy"}, stallOk, 1'b1);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s);
    logic [W-1:0] q, r;
    bit dz;
    model(a, b, s, q, r, dz);
    @(negedge clk);
    startOp(tag, a, b, s);
    waitDone(tag, 0, dz ? 1 : 34, q, r, dz);
  endtask

  initial begin
    logic [W-1:0] a, b, q, r, q0, r0;
    bit s, dz, doneSeen;

    reset = 1'b1; StartE = 1'b0; SignedE = 1'b0; FlushE = 1'b0;
    DividendE = '0; DivisorE = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", QuotientE, 0);
    chk("rst_r", RemainderE, 0);
    chk("rst_dz", DivZeroE, 0);
    chk("rst_done", DoneE, 0);
    chk("rst_stall", StallDivE, 0);
    reset = 1'b0;

    runOp("udiv", 32'd100, 32'd7, 1'b0);
    chk("udiv_q14", QuotientE, 32'd14);
    runOp("sdiv_nd", -32'sd100, 32'd7, 1'b1);
    chk("sdiv_nd_q", QuotientE, 32'hFFFF_FFF2);
    chk("sdiv_nd_r", RemainderE, 32'hFFFF_FFFE);
    runOp("sdiv_nv", 32'd100, -32'sd7, 1'b1);
    runOp("sdiv_nn", -32'sd100, -32'sd7, 1'b1);
    runOp("divzero", 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("divzero_r", RemainderE, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("divzero_stall_after", StallDivE, 1'b0);
    runOp("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("ovf_q", QuotientE, 32'h8000_0000);
    runOp("ufull", 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Back-to-back: new request held during the DONE cycle.
    runOp("b2b1", 32'd100, 32'd7, 1'b0);
    startOp("b2b2", 32'd50, 32'd5, 1'b0);
    waitDone("b2b2", 0, 34, 32'd10, 32'd0, 1'b0);

    // Start pulsed mid-DIV must be ignored.
    @(negedge clk);
    startOp("ign", 32'd1000, 32'd9, 1'b0);
    repeat (5) begin @(negedge clk); StartE = 1'b0; end
    StartE = 1'b1; DividendE = 32'd9; DivisorE = 32'd3;
    @(negedge clk);
    StartE = 1'b0;
    waitDone("ign", 6, 34, 32'd111, 32'd1, 1'b0);

    // Flush at DIV iteration 10: no completion, results kept.
    q0 = QuotientE; r0 = RemainderE;
    @(negedge clk);
    startOp("flush", 32'd100, 32'd7, 1'b0);
    repeat (10) begin @(negedge clk); StartE = 1'b0; end
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    #1;
    chk("flush_stall_drop", StallDivE, 1'b0);
    doneSeen = 1'b0;
    repeat (40) begin @(negedge clk); if (DoneE) doneSeen = 1'b1; end
    chk("flush_no_done", doneSeen, 1'b0);
    chk("flush_keep_q", QuotientE, q0);
    chk("flush_keep_r", RemainderE, r0);

    // Start together with flush in IDLE is refused.
    StartE = 1'b1; FlushE = 1'b1; DividendE = 32'd20; DivisorE = 32'd4; SignedE = 1'b0;
    #1;
    chk("sf_stall", StallDivE, 1'b0);
    @(negedge clk);
    StartE = 1'b0; FlushE = 1'b0;
    doneSeen = 1'b0;
    repeat (40) begin @(negedge clk); if (DoneE || StallDivE) doneSeen = 1'b1; end
    chk("sf_no_accept", doneSeen, 1'b0);
    chk("sf_keep_q", QuotientE, q0);

    // Reset in the middle of a divide.
    @(negedge clk);
    startOp("rmid", 32'd77, 32'd5, 1'b0);
    repeat (8) begin @(negedge clk); StartE = 1'b0; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmid_q", QuotientE, 0);
    chk("rmid_r", RemainderE, 0);
    chk("rmid_dz", DivZeroE, 0);
    chk("rmid_done", DoneE, 0);
    chk("rmid_stall", StallDivE, 0);
    runOp("after_rst", 32'd77, 32'd5, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = -($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      runOp($sformatf("rnd%0d", i), a, b, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
